// File: rtl/cfs_algn_pkg.sv
// Field packing shared by the aligner FIFOs, TX arbiter and TX path.
// A FIFO word is {size, offset, data} with data in the LSBs.
package cfs_algn_pkg;

  function automatic int unsigned algn_offset_width(input int unsigned dw);
    return (dw <= 8) ? 1 : $clog2(dw / 8);
  endfunction

  function automatic int unsigned algn_size_width(input int unsigned dw);
    return $clog2(dw / 8) + 1;
  endfunction

  function automatic int unsigned fifo_data_width(input int unsigned dw);
    return dw + algn_offset_width(dw) + algn_size_width(dw);
  endfunction

  function automatic int unsigned data_lsb(input int unsigned dw);
    return 0;
  endfunction

  function automatic int unsigned data_msb(input int unsigned dw);
    return dw - 1;
  endfunction

  function automatic int unsigned offset_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned offset_msb(input int unsigned dw);
    return dw + algn_offset_width(dw) - 1;
  endfunction

  function automatic int unsigned size_lsb(input int unsigned dw);
    return dw + algn_offset_width(dw);
  endfunction

  function automatic int unsigned size_msb(input int unsigned dw);
    return fifo_data_width(dw) - 1;
  endfunction

endpackage

// File: rtl/cfs_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start,
// wrapping modulo N.
module cfs_rr_pick #(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [SUM_W-1:0] sum;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    sum   = '0;
    req2  = {req, req};
    rot   = N'(req2 >> start);
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        sum = SUM_W'(start) + SUM_W'(k);
        if (sum >= SUM_W'(N)) sum = sum - SUM_W'(N);
        grant = IDX_W'(sum);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cfs_tx_arb.sv
// Round-robin TX arbiter with bounded burst lock feeding a single registered
// MD TX output stage.
module cfs_tx_arb
  import cfs_algn_pkg::*;
#(
  parameter int unsigned ALGN_DATA_WIDTH = 32,
  parameter int unsigned NUM_SRC         = 2,
  parameter int unsigned MAX_BURST       = 4,
  localparam int unsigned ALGN_OFFSET_WIDTH = algn_offset_width(ALGN_DATA_WIDTH),
  localparam int unsigned ALGN_SIZE_WIDTH   = algn_size_width(ALGN_DATA_WIDTH),
  localparam int unsigned FIFO_DATA_WIDTH   = fifo_data_width(ALGN_DATA_WIDTH),
  localparam int unsigned SRC_W             = $clog2(NUM_SRC),
  localparam int unsigned BCNT_W            = $clog2(MAX_BURST + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_SRC-1:0]                 src_en,
  input  logic [NUM_SRC-1:0]                 pop_valid,
  input  logic [NUM_SRC*FIFO_DATA_WIDTH-1:0] pop_data,
  output logic [NUM_SRC-1:0]                 pop_ready,
  output logic                               md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]         md_tx_data,
  output logic [ALGN_OFFSET_WIDTH-1:0]       md_tx_offset,
  output logic [ALGN_SIZE_WIDTH-1:0]         md_tx_size,
  input  logic                               md_tx_ready,
  output logic [SRC_W-1:0]                   md_tx_src
);

  localparam int unsigned D_MSB = data_msb(ALGN_DATA_WIDTH);
  localparam int unsigned D_LSB = data_lsb(ALGN_DATA_WIDTH);
  localparam int unsigned O_MSB = offset_msb(ALGN_DATA_WIDTH);
  localparam int unsigned O_LSB = offset_lsb(ALGN_DATA_WIDTH);
  localparam int unsigned S_MSB = size_msb(ALGN_DATA_WIDTH);
  localparam int unsigned S_LSB = size_lsb(ALGN_DATA_WIDTH);

  logic                         valid_q, valid_d;
  logic [ALGN_DATA_WIDTH-1:0]   data_q, data_d;
  logic [ALGN_OFFSET_WIDTH-1:0] offset_q, offset_d;
  logic [ALGN_SIZE_WIDTH-1:0]   size_q, size_d;
  logic [SRC_W-1:0]             src_q, src_d;
  logic [SRC_W-1:0]             last_q, last_d;
  logic [BCNT_W-1:0]            burst_cnt_q, burst_cnt_d;

  logic [FIFO_DATA_WIDTH-1:0] words [NUM_SRC];
  logic [FIFO_DATA_WIDTH-1:0] sel_word_c;
  logic [NUM_SRC-1:0]         req_c;
  logic [SRC_W-1:0]           start_c, pick_c, win_c;
  logic                       any_c, load_en_c, lock_c, xfer_c;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      words[i] = pop_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
    end
  end

  // Search always begins one past the last winner; the lock overrides it.
  assign start_c = (last_q == SRC_W'(NUM_SRC - 1)) ? '0 : last_q + SRC_W'(1);

  cfs_rr_pick #(
    .N (NUM_SRC)
  ) u_pick (
    .req   (req_c),
    .start (start_c),
    .grant (pick_c),
    .any   (any_c)
  );

  always_comb begin
    req_c       = pop_valid & src_en;
    load_en_c   = !valid_q || md_tx_ready;
    lock_c      = req_c[last_q] && (burst_cnt_q != '0) &&
                  (burst_cnt_q < BCNT_W'(MAX_BURST));
    win_c       = lock_c ? last_q : pick_c;
    xfer_c      = load_en_c && any_c;
    sel_word_c  = words[win_c];
    pop_ready   = '0;
    valid_d     = valid_q;
    data_d      = data_q;
    offset_d    = offset_q;
    size_d      = size_q;
    src_d       = src_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer_c) begin
      pop_ready[win_c] = 1'b1;
      valid_d     = 1'b1;
      data_d      = sel_word_c[D_MSB:D_LSB];
      offset_d    = sel_word_c[O_MSB:O_LSB];
      size_d      = sel_word_c[S_MSB:S_LSB];
      src_d       = win_c;
      last_d      = win_c;
      // Continuing the lock extends the burst; any other grant starts a new one.
      burst_cnt_d = lock_c ? burst_cnt_q + BCNT_W'(1) : BCNT_W'(1);
    end else if (load_en_c) begin
      valid_d     = 1'b0;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      offset_q    <= '0;
      size_q      <= '0;
      src_q       <= '0;
      last_q      <= SRC_W'(NUM_SRC - 1);
      burst_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      offset_q    <= offset_d;
      size_q      <= size_d;
      src_q       <= src_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign md_tx_valid  = valid_q;
  assign md_tx_data   = data_q;
  assign md_tx_offset = offset_q;
  assign md_tx_size   = size_q;
  assign md_tx_src    = src_q;

endmodule
